rvx_block_copier: RTL and testbench
===================================

// Module: rvx_block_copier
// PURPOSE
//  Bus initiator that copies a block of 32-bit words from src to dst address on
//  the rvx request/response memory bus (the same port set as the RAM responder).
//  Sits beside the CPU as a simple DMA master; a single-word transfer is in flight at a time.
//  Reports completion or a responder timeout through done/error status.
// PARAMETERS
//  COUNT_WIDTH     16   width of word_count and the internal remaining-word counter
//  TIMEOUT_CYCLES  255  max cycles spent waiting for any response before error (>=1)
// PORTS
//  clock          in   1            single clock; all logic on posedge
//  reset          in   1            synchronous, active-high
//  start          in   1            begin copy; sampled only in IDLE
//  abort          in   1            cancel an active copy
//  src_address    in   32           source byte address; bits [1:0] ignored
//  dst_address    in   32           destination byte address; bits [1:0] ignored
//  word_count     in   COUNT_WIDTH  number of 32-bit words to copy
//  busy           out  1            high while not IDLE
//  done           out  1            one-cycle pulse at end of copy (success or timeout)
//  error          out  1            set with done on timeout; held until next accepted start
//  rw_address     out  32           bus address, always word aligned
//  read_data      in   32           bus read data, valid with read_response
//  read_request   out  1            one-cycle read request pulse
//  read_response  in   1            read completion
//  write_data     out  32           word captured from read
//  write_strobe   out  4            4'b1111 during a write, else 4'b0000
//  write_request  out  1            one-cycle write request pulse
//  write_response in   1            write completion
// BEHAVIOUR
//  - All outputs registered. On reset (next edge): state IDLE, every output 0.
//    Reset mid-copy: no further requests; pending responses are ignored.
//  - States: IDLE, READ_REQ, READ_WAIT, WRITE_REQ, WRITE_WAIT, FINISH.
//  - IDLE: start=1 and abort=0 -> latch src/dst with [1:0]=0 and word_count;
//    clear error; go READ_REQ, or FINISH if word_count==0 (no bus activity).
//    start and abort together in IDLE: abort wins, start ignored.
//  - READ_REQ (1 cycle): read_request=1, rw_address=src -> READ_WAIT.
//  - READ_WAIT: read_request=0, rw_address held. read_response=1 -> capture
//    read_data into write_data -> WRITE_REQ.
//  - WRITE_REQ (1 cycle): write_request=1, write_strobe=4'b1111, rw_address=dst
//    -> WRITE_WAIT.
//  - WRITE_WAIT: request low; write_data and strobe held until write_response.
//    write_response=1 -> src+=4, dst+=4 (32-bit modulo wrap), remaining-=1;
//    remaining now 0 -> FINISH, else READ_REQ.
//  - FINISH (1 cycle): done=1 -> IDLE. busy is 0 in IDLE only.
//  - Timeout: a counter clears on entering each WAIT state and increments per
//    WAIT cycle without the expected response. When it reaches TIMEOUT_CYCLES ->
//    error=1, go FINISH (done pulses with error=1). A response in that same
//    cycle takes priority over timeout.
//  - abort=1 in any non-IDLE state -> IDLE next edge, no done pulse, error
//    unchanged, requests deasserted. Abort outranks response and timeout.
//  - Responses arriving outside the matching WAIT state are ignored.
//  - Latency, zero-wait responder: 4 cycles per word. done is high in cycle
//    4N+1 after the edge that sampled start (cycle 1 for N=0).
//  - Copy order is ascending; src/dst overlap is not handled.
// STRUCTURE
//  - State encoding, remaining counter and address registers are local to this module.
//  - Shared package/header: bus constant STROBE_WORD=4'b1111, WORD_BYTES=4.
//  - One sub-module: rvx_timeout_counter (clear, enable, expired at TIMEOUT_CYCLES).
// TESTING
//  1 With rvx_ram (8 KiB), preload 0x100..0x10C = 11,22,33,44. src=0x100,
//    dst=0x200, N=4 -> 0x200..0x20C equal 11,22,33,44; done in cycle 17,
//    error=0; exactly 4 read and 4 write pulses.
//  2 N=0, start -> done in cycle 1, busy high for 1 cycle, no request pulses.
//  3 Silent responder, TIMEOUT_CYCLES=8, N=1 -> read_request once; done+error
//    after 8 READ_WAIT cycles; error stays 1 until next start.
//  4 N=10, assert abort on the 3rd write_request -> busy low next cycle, no
//    done, no further requests; dst words 0-1 written, words 3-9 untouched.
//  5 src=0xFFFFFFFC, dst=0x0, N=2, stub responder -> read addresses
//    0xFFFFFFFC then 0x00000000 (wrap); src=0x103 -> first rw_address=0x100.
//  6 Reset asserted during WRITE_WAIT -> next cycle all outputs 0,
//    state IDLE; a late write_response produces no done.

Source files
------------

// File: rtl/rvx_block_copier_pkg.sv
// rvx_block_copier_pkg: shared bus constants, FSM states and address helper for the block copier.
package rvx_block_copier_pkg;
    localparam logic [3:0]  STROBE_WORD = 4'b1111;
    localparam logic [31:0] WORD_BYTES  = 32'd4;
    typedef enum logic [2:0] {
        IDLE,
        READ_REQ,
        READ_WAIT,
        WRITE_REQ,
        WRITE_WAIT,
        FINISH
    } state_e;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/rvx_block_copier_if.sv
// rvx_block_copier_if: rvx request/response memory bus, initiator (master) and responder (slave) views.
interface rvx_block_copier_if;
    logic [31:0] rw_address;
    logic [31:0] read_data;
    logic        read_request;
    logic        read_response;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_request;
    logic        write_response;
    modport master (
        output rw_address, read_request, write_data, write_strobe, write_request,
        input  read_data, read_response, write_response
    );
    modport slave (
        input  rw_address, read_request, write_data, write_strobe, write_request,
        output read_data, read_response, write_response
    );
endinterface

// File: rtl/rvx_block_copier_timeout.sv
// rvx_timeout_counter: counts wait cycles; expired is high in the cycle the count would reach the limit.
module rvx_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) cnt_q <= '0;
        else if (enable_i) cnt_q <= cnt_q + W'(1);
    end
    assign expired_o = enable_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/rvx_block_copier.sv
// rvx_block_copier: single-outstanding-word DMA copier on the rvx bus with abort and response timeout.
module rvx_block_copier
    import rvx_block_copier_pkg::*;
#(
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [31:0]            src_address_i,
    input  logic [31:0]            dst_address_i,
    input  logic [COUNT_WIDTH-1:0] word_count_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    rvx_block_copier_if.master     bus
);
    state_e state_q, state_d;
    logic [31:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [3:0] strobe_q, strobe_d;
    logic rd_req_q, rd_req_d, wr_req_q, wr_req_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic expired;
    rvx_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == READ_REQ || state_q == WRITE_REQ),
        .enable_i  (state_q == READ_WAIT || state_q == WRITE_WAIT),
        .expired_o (expired)
    );
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        if (abort_i && state_q != IDLE) state_d = IDLE;
        else begin
            unique case (state_q)
                IDLE: if (start_i && !abort_i) begin
                    src_d   = word_align(src_address_i);
                    dst_d   = word_align(dst_address_i);
                    rem_d   = word_count_i;
                    err_d   = 1'b0;
                    state_d = (word_count_i == '0) ? FINISH : READ_REQ;
                end
                READ_REQ:  state_d = READ_WAIT;
                READ_WAIT: if (bus.read_response) begin
                    wdata_d = bus.read_data;
                    state_d = WRITE_REQ;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
                WRITE_REQ:  state_d = WRITE_WAIT;
                WRITE_WAIT: if (bus.write_response) begin
                    src_d   = src_q + WORD_BYTES;
                    dst_d   = dst_q + WORD_BYTES;
                    rem_d   = rem_q - COUNT_WIDTH'(1);
                    state_d = (rem_q == COUNT_WIDTH'(1)) ? FINISH : READ_REQ;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
                default: state_d = IDLE;
            endcase
        end
        // outputs are decoded from the next state so every port comes straight from a flop
        rd_req_d = state_d == READ_REQ;
        wr_req_d = state_d == WRITE_REQ;
        strobe_d = (state_d == WRITE_REQ || state_d == WRITE_WAIT) ? STROBE_WORD : 4'b0000;
        done_d   = state_d == FINISH;
        busy_d   = state_d != IDLE;
        addr_d   = (state_d == READ_REQ || state_d == READ_WAIT) ? src_d :
                   (state_d == WRITE_REQ || state_d == WRITE_WAIT) ? dst_d : addr_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign error_o           = err_q;
    assign bus.rw_address    = addr_q;
    assign bus.read_request  = rd_req_q;
    assign bus.write_request = wr_req_q;
    assign bus.write_data    = wdata_q;
    assign bus.write_strobe  = strobe_q;
endmodule

// File: tb/tb_rvx_block_copier.sv
// tb_rvx_block_copier: table-driven copies against a behavioural RAM plus timeout, abort, wrap and reset sequences.
module tb_rvx_block_copier;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic [15:0] cnt = '0;
    logic busy, done, error;
    rvx_block_copier_if bus();
    rvx_block_copier #(.COUNT_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .src_address_i(src), .dst_address_i(dst), .word_count_i(cnt),
        .busy_o(busy), .done_o(done), .error_o(error), .bus(bus)
    );
    always #5 clk = ~clk;

    logic [31:0] mem [0:2047];
    logic silent = 1'b0, silent_wr = 1'b0, late_wr = 1'b0, rd_resp_q = 1'b0, wr_resp_q = 1'b0;
    logic [31:0] rdata_q = '0;
    assign bus.read_response  = rd_resp_q;
    assign bus.read_data      = rdata_q;
    assign bus.write_response = wr_resp_q | late_wr;
    always @(posedge clk) begin
        rd_resp_q <= bus.read_request && !silent;
        wr_resp_q <= bus.write_request && !silent && !silent_wr;
        if (bus.read_request) rdata_q <= mem[bus.rw_address[12:2]];
        if (bus.write_request && !silent) mem[bus.rw_address[12:2]] <= bus.write_data;
    end

    int errors = 0, checks = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        src = s; dst = d; cnt = n; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // cycles counted from the edge that sampled start; cyc stays 0 if done never arrives
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       output int cyc, output int rd, output int wr, output int bz,
                       output logic [31:0] a0, output logic e);
        kick(s, d, n);
        cyc = 0; rd = 0; wr = 0; bz = 0; a0 = '0; e = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (busy) bz++;
            if (bus.read_request) begin
                if (rd == 0) a0 = bus.rw_address;
                rd++;
            end
            if (bus.write_request) begin
                wr++;
                check("write_strobe", {28'd0, bus.write_strobe}, 32'hF);
            end
            if (done) begin
                cyc = c;
                e = error;
                break;
            end
        end
    endtask

    typedef struct {
        logic [31:0] s, d;
        logic [15:0] n;
        logic [31:0] base;
        int          cyc;
        logic [31:0] a0;
    } vec_t;
    vec_t vecs [4];

    initial begin
        int cyc, rd, wr, bz, k;
        logic [31:0] a0, a1;
        logic e, hit;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        vecs[0] = '{32'h100, 32'h200, 16'd4, 32'd11,        17, 32'h100};
        vecs[1] = '{32'h300, 32'h400, 16'd1, 32'h5A5A0001,  5, 32'h300};
        vecs[2] = '{32'h103, 32'h502, 16'd3, 32'h77,        13, 32'h100};
        vecs[3] = '{32'h000, 32'h800, 16'd0, 32'h0,          1, 32'h0};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset error", {31'd0, error}, 0);
        check("reset rw_address", bus.rw_address, 0);
        check("reset read_request", {31'd0, bus.read_request}, 0);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < int'(vecs[v].n); i++)
                mem[((vecs[v].s >> 2) + i) & 2047] = vecs[v].base * (i + 1);
            for (int i = 0; i <= int'(vecs[v].n); i++)
                mem[((vecs[v].d >> 2) + i) & 2047] = 32'hDEADBEEF;
            run(vecs[v].s, vecs[v].d, vecs[v].n, cyc, rd, wr, bz, a0, e);
            check($sformatf("v%0d done cycle", v), cyc, vecs[v].cyc);
            check($sformatf("v%0d error", v), {31'd0, e}, 0);
            check($sformatf("v%0d reads", v), rd, vecs[v].n);
            check($sformatf("v%0d writes", v), wr, vecs[v].n);
            check($sformatf("v%0d busy cycles", v), bz, 4 * vecs[v].n + 1);
            if (vecs[v].n != 0) check($sformatf("v%0d first addr", v), a0, vecs[v].a0);
            for (int i = 0; i < int'(vecs[v].n); i++)
                check($sformatf("v%0d dst[%0d]", v, i), mem[((vecs[v].d >> 2) + i) & 2047], vecs[v].base * (i + 1));
            check($sformatf("v%0d dst past end", v), mem[((vecs[v].d >> 2) + vecs[v].n) & 2047], 32'hDEADBEEF);
            @(negedge clk);
            check($sformatf("v%0d busy after done", v), {31'd0, busy}, 0);
            check($sformatf("v%0d done pulse width", v), {31'd0, done}, 0);
        end

        silent = 1'b1;
        run(32'h100, 32'h200, 16'd1, cyc, rd, wr, bz, a0, e);
        check("timeout done cycle", cyc, 10);
        check("timeout error", {31'd0, e}, 1);
        check("timeout reads", rd, 1);
        check("timeout writes", wr, 0);
        repeat (5) @(negedge clk);
        check("timeout error held", {31'd0, error}, 1);
        check("timeout busy idle", {31'd0, busy}, 0);
        silent = 1'b0;
        run(32'h100, 32'h200, 16'd0, cyc, rd, wr, bz, a0, e);
        check("restart clears error", {31'd0, e}, 0);
        check("restart done cycle", cyc, 1);

        for (int i = 0; i < 10; i++) mem[(32'h600 >> 2) + i] = 32'h1000 + i;
        for (int i = 0; i < 10; i++) mem[(32'h700 >> 2) + i] = 32'hDEADBEEF;
        kick(32'h600, 32'h700, 16'd10);
        k = 0; hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.write_request) k++;
            if (k == 3) begin
                abort = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        check("abort third write seen", {31'd0, hit}, 1);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort busy", {31'd0, busy}, 0);
        check("abort write_request", {31'd0, bus.write_request}, 0);
        rd = 0; wr = 0; k = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.read_request) rd++;
            if (bus.write_request) wr++;
            if (done) k++;
        end
        check("abort no reads", rd, 0);
        check("abort no writes", wr, 0);
        check("abort no done", k, 0);
        check("abort error kept", {31'd0, error}, 0);
        check("abort dst[0]", mem[(32'h700 >> 2) + 0], 32'h1000);
        check("abort dst[1]", mem[(32'h700 >> 2) + 1], 32'h1001);
        for (int i = 3; i < 10; i++)
            check($sformatf("abort dst[%0d] untouched", i), mem[(32'h700 >> 2) + i], 32'hDEADBEEF);

        kick(32'hFFFFFFFC, 32'h0, 16'd2);
        rd = 0; a0 = '0; a1 = '0; cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.read_request) begin
                if (rd == 0) a0 = bus.rw_address; else a1 = bus.rw_address;
                rd++;
            end
            if (done) begin
                cyc = c;
                break;
            end
        end
        check("wrap read addr 0", a0, 32'hFFFFFFFC);
        check("wrap read addr 1", a1, 32'h0);
        check("wrap done cycle", cyc, 9);

        @(negedge clk);
        cnt = 16'd1; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start+abort busy", {31'd0, busy}, 0);
        check("start+abort read_request", {31'd0, bus.read_request}, 0);

        silent_wr = 1'b1;
        kick(32'h100, 32'h200, 16'd2);
        hit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.write_request) begin
                hit = 1'b1;
                break;
            end
        end
        check("reset test write seen", {31'd0, hit}, 1);
        @(negedge clk);
        check("write_wait strobe held", {28'd0, bus.write_strobe}, 32'hF);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset busy", {31'd0, busy}, 0);
        check("midreset done", {31'd0, done}, 0);
        check("midreset strobe", {28'd0, bus.write_strobe}, 0);
        check("midreset rw_address", bus.rw_address, 0);
        check("midreset write_data", bus.write_data, 0);
        silent_wr = 1'b0;
        late_wr = 1'b1;
        @(posedge clk);
        #1 late_wr = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) k++;
        end
        check("late response ignored", k, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
